// File: rtl/ame_pkg.sv
// Shared types and register map for the AME solver controller.
package ame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMP,
        ST_WB_AW,
        ST_WB_W,
        ST_WB_B
    } state_e;

    // Byte offsets, decoded on addr[9:0] with an 8-byte stride
    localparam logic [9:0] OFF_WB_BASE = 10'h000;
    localparam logic [9:0] OFF_CTRL    = 10'h008;
    localparam logic [9:0] OFF_STATUS  = 10'h010;
    localparam logic [9:0] OFF_RESULT  = 10'h040;
    localparam logic [9:0] OFF_MATRIX  = 10'h200;

    localparam int CTRL_START  = 0;
    localparam int CTRL_PARAM6 = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_WB_EN  = 3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_BERR = 2;

    localparam logic [1:0] BURST_INCR = 2'b01;

    // 64-bit word index of a byte offset
    function automatic logic [6:0] word_of(input logic [9:0] off);
        return off[9:3];
    endfunction

endpackage

// File: rtl/axi_ame_ctrl_if.sv
// Register-slave and write-back-master AXI signals of the AME controller.
interface axi_ame_ctrl_if #(
    parameter int DATA_BITS = 64,
    parameter int ADDR_BITS = 32
);
    logic [ADDR_BITS-1:0]   s_axi_awaddr;
    logic                   s_axi_awvalid, s_axi_awready;
    logic [DATA_BITS-1:0]   s_axi_wdata;
    logic                   s_axi_wvalid, s_axi_wready;
    logic                   s_axi_bvalid, s_axi_bready;
    logic [ADDR_BITS-1:0]   s_axi_araddr;
    logic                   s_axi_arvalid, s_axi_arready;
    logic [DATA_BITS-1:0]   s_axi_rdata;
    logic                   s_axi_rvalid, s_axi_rready;

    logic [ADDR_BITS-1:0]   m_axi_awaddr;
    logic [7:0]             m_axi_awlen;
    logic [2:0]             m_axi_awsize;
    logic [1:0]             m_axi_awburst;
    logic                   m_axi_awlock;
    logic [3:0]             m_axi_awcache;
    logic [2:0]             m_axi_awprot;
    logic [3:0]             m_axi_awqos;
    logic                   m_axi_awvalid, m_axi_awready;
    logic [DATA_BITS-1:0]   m_axi_wdata;
    logic [DATA_BITS/8-1:0] m_axi_wstrb;
    logic                   m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]             m_axi_bresp;
    logic                   m_axi_bvalid, m_axi_bready;

    // Register port as seen by the block
    modport s_slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
               s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
               s_axi_rdata, s_axi_rvalid
    );

    // Register port as seen by the host
    modport s_master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
               s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
               s_axi_rdata, s_axi_rvalid
    );

    // Write-back port as seen by the block
    modport m_master (
        output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
               m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
               m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
    );

    // Write-back port as seen by memory
    modport m_slave (
        input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
               m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
               m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
    );

endinterface

// File: rtl/axi_ame_wb.sv
// Result write-back: one INCR burst of N_RES beats to i_base, then wait for B.
module axi_ame_wb
    import ame_pkg::*;
#(
    parameter int DATA_BITS = 64,
    parameter int ADDR_BITS = 32,
    parameter int N_RES     = 6
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_start,
    input  logic [ADDR_BITS-1:0]             i_base,
    input  logic [N_RES-1:0][DATA_BITS-1:0]  i_results,
    output logic                             o_done,
    output logic                             o_berr,
    axi_ame_ctrl_if.m_master                 m_bus
);

    state_e               r_state;
    logic [4:0]           r_beat;
    logic [ADDR_BITS-1:0] r_awaddr;
    logic                 r_awvalid, r_wvalid, r_wlast, r_bready, r_done, r_berr;
    logic [DATA_BITS-1:0] r_wdata, w_next_data;
    logic [4:0]           w_beat_nxt;

    assign w_beat_nxt = r_beat + 5'd1;

    // Select the result word for the following beat
    always_comb begin
        w_next_data = '0;
        for (int k = 0; k < N_RES; k++)
            if (w_beat_nxt == 5'(k)) w_next_data = i_results[k];
    end

    assign m_bus.m_axi_awaddr  = r_awaddr;
    assign m_bus.m_axi_awlen   = 8'(N_RES - 1);
    assign m_bus.m_axi_awsize  = 3'($clog2(DATA_BITS / 8));
    assign m_bus.m_axi_awburst = BURST_INCR;
    assign m_bus.m_axi_awlock  = 1'b0;
    assign m_bus.m_axi_awcache = 4'd2;
    assign m_bus.m_axi_awprot  = 3'd0;
    assign m_bus.m_axi_awqos   = 4'd0;
    assign m_bus.m_axi_awvalid = r_awvalid;
    assign m_bus.m_axi_wdata   = r_wdata;
    assign m_bus.m_axi_wstrb   = '1;
    assign m_bus.m_axi_wlast   = r_wlast;
    assign m_bus.m_axi_wvalid  = r_wvalid;
    assign m_bus.m_axi_bready  = r_bready;
    assign o_done              = r_done;
    assign o_berr              = r_berr;

    // Burst sequencer; all bus outputs are registered so they hold through stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_beat    <= '0;
            r_awaddr  <= '0;
            r_awvalid <= 1'b0;
            r_wdata   <= '0;
            r_wvalid  <= 1'b0;
            r_wlast   <= 1'b0;
            r_bready  <= 1'b0;
            r_done    <= 1'b0;
            r_berr    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (i_start) begin
                    r_awaddr  <= i_base;
                    r_awvalid <= 1'b1;
                    r_state   <= ST_WB_AW;
                end
                ST_WB_AW: if (m_bus.m_axi_awready) begin
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b1;
                    r_wdata   <= i_results[0];
                    r_wlast   <= (N_RES == 1);
                    r_beat    <= '0;
                    r_state   <= ST_WB_W;
                end
                ST_WB_W: if (m_bus.m_axi_wready) begin
                    if (r_wlast) begin
                        r_wvalid <= 1'b0;
                        r_wlast  <= 1'b0;
                        r_bready <= 1'b1;
                        r_state  <= ST_WB_B;
                    end else begin
                        r_beat  <= w_beat_nxt;
                        r_wdata <= w_next_data;
                        r_wlast <= (w_beat_nxt == 5'(N_RES - 1));
                    end
                end
                ST_WB_B: if (m_bus.m_axi_bvalid) begin
                    r_bready <= 1'b0;
                    r_done   <= 1'b1;
                    r_berr   <= (m_bus.m_axi_bresp != 2'b00);
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axi_ame_ctrl.sv
// AME solver controller: AXI register file, solver handshake, result write-back.
module axi_ame_ctrl
    import ame_pkg::*;
#(
    parameter int DATA_BITS = 64,
    parameter int ROWS      = 6,
    parameter int COLS      = 7,
    parameter int N_RES     = 6,
    parameter int ADDR_BITS = 32
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_aresetn,
    axi_ame_ctrl_if.s_slave                s_bus,
    axi_ame_ctrl_if.m_master               m_bus,
    output logic                           comp_init_o,
    output logic                           affine_param6_o,
    output logic [ROWS*COLS*DATA_BITS-1:0] comp_data_o,
    input  logic                           comp_done_i,
    input  logic [N_RES*DATA_BITS-1:0]     comp_data_i,
    output logic                           irq_o
);

    localparam logic [6:0] W_RES = word_of(OFF_RESULT);
    localparam logic [6:0] W_MAT = word_of(OFF_MATRIX);

    state_e                                r_state;
    logic [ADDR_BITS-1:0]                  r_wb_base;
    logic [3:1]                            r_ctrl;
    logic                                  r_done, r_berr, r_comp_init, r_wb_start;
    logic                                  r_bvalid, r_rvalid;
    logic [DATA_BITS-1:0]                  r_rdata, w_rd_data;
    logic [ROWS*COLS-1:0][DATA_BITS-1:0]   r_matrix;
    logic [N_RES-1:0][DATA_BITS-1:0]       r_result;
    logic                                  w_busy, w_wr_acc, w_rd_acc, w_start;
    logic                                  w_wb_done, w_wb_berr, w_unused;
    logic [6:0]                            w_wr_word, w_rd_word;

    assign w_busy    = (r_state != ST_IDLE);
    assign w_wr_acc  = s_bus.s_axi_awvalid & s_bus.s_axi_wvalid & (~r_bvalid | s_bus.s_axi_bready);
    assign w_rd_acc  = s_bus.s_axi_arvalid & (~r_rvalid | s_bus.s_axi_rready);
    assign w_wr_word = s_bus.s_axi_awaddr[9:3];
    assign w_rd_word = s_bus.s_axi_araddr[9:3];
    assign w_start   = w_wr_acc & (w_wr_word == word_of(OFF_CTRL)) &
                       s_bus.s_axi_wdata[CTRL_START] & ~w_busy;
    assign w_unused  = ^{s_bus.s_axi_awaddr[ADDR_BITS-1:10], s_bus.s_axi_awaddr[2:0],
                         s_bus.s_axi_araddr[ADDR_BITS-1:10], s_bus.s_axi_araddr[2:0]};

    assign s_bus.s_axi_awready = w_wr_acc;
    assign s_bus.s_axi_wready  = w_wr_acc;
    assign s_bus.s_axi_bvalid  = r_bvalid;
    assign s_bus.s_axi_arready = w_rd_acc;
    assign s_bus.s_axi_rdata   = r_rdata;
    assign s_bus.s_axi_rvalid  = r_rvalid;

    assign comp_init_o     = r_comp_init;
    assign affine_param6_o = r_ctrl[CTRL_PARAM6];
    assign comp_data_o     = r_matrix;
    assign irq_o           = r_done & r_ctrl[CTRL_IRQ_EN];

    // Register read decode; unmapped words read as zero
    always_comb begin
        w_rd_data = '0;
        if (w_rd_word == word_of(OFF_WB_BASE)) w_rd_data = DATA_BITS'(r_wb_base);
        if (w_rd_word == word_of(OFF_CTRL))    w_rd_data[3:1] = r_ctrl;
        if (w_rd_word == word_of(OFF_STATUS)) begin
            w_rd_data[STAT_BUSY] = w_busy;
            w_rd_data[STAT_DONE] = r_done;
            w_rd_data[STAT_BERR] = r_berr;
        end
        for (int i = 0; i < N_RES; i++)
            if (w_rd_word == W_RES + 7'(i)) w_rd_data = r_result[i];
        for (int k = 0; k < ROWS*COLS; k++)
            if (w_rd_word == W_MAT + 7'(k)) w_rd_data = r_matrix[k];
    end

    // Slave response channels: B held until bready, R held until rready
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_bvalid <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_wr_acc)               r_bvalid <= 1'b1;
            else if (s_bus.s_axi_bready) r_bvalid <= 1'b0;
            if (w_rd_acc) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
            end else if (s_bus.s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // Register writes and control FSM; a DONE set later in the block overrides a W1C
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state     <= ST_IDLE;
            r_wb_base   <= '0;
            r_ctrl      <= '0;
            r_done      <= 1'b0;
            r_berr      <= 1'b0;
            r_comp_init <= 1'b0;
            r_wb_start  <= 1'b0;
            r_matrix    <= '0;
            r_result    <= '0;
        end else begin
            r_comp_init <= 1'b0;
            r_wb_start  <= 1'b0;
            if (w_wr_acc) begin
                if (w_wr_word == word_of(OFF_WB_BASE))
                    r_wb_base <= s_bus.s_axi_wdata[ADDR_BITS-1:0];
                if (w_wr_word == word_of(OFF_CTRL) && !w_busy)
                    r_ctrl <= s_bus.s_axi_wdata[3:1];
                if (w_wr_word == word_of(OFF_STATUS)) begin
                    if (s_bus.s_axi_wdata[STAT_DONE]) r_done <= 1'b0;
                    if (s_bus.s_axi_wdata[STAT_BERR]) r_berr <= 1'b0;
                end
                for (int k = 0; k < ROWS*COLS; k++)
                    if (!w_busy && w_wr_word == W_MAT + 7'(k))
                        r_matrix[k] <= s_bus.s_axi_wdata;
            end
            case (r_state)
                ST_IDLE: if (w_start) begin
                    r_comp_init <= 1'b1;
                    r_done      <= 1'b0;
                    r_berr      <= 1'b0;
                    r_state     <= ST_COMP;
                end
                ST_COMP: if (comp_done_i) begin
                    r_result <= comp_data_i;
                    if (r_ctrl[CTRL_WB_EN]) begin
                        r_wb_start <= 1'b1;
                        r_state    <= ST_WB_AW;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                // Write-back phases are sequenced inside axi_ame_wb
                default: if (w_wb_done) begin
                    r_done <= 1'b1;
                    if (w_wb_berr) r_berr <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    axi_ame_wb #(
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (ADDR_BITS),
        .N_RES     (N_RES)
    ) u_wb (
        .clk       (s_axi_aclk),
        .rst_n     (s_axi_aresetn),
        .i_start   (r_wb_start),
        .i_base    (r_wb_base),
        .i_results (r_result),
        .o_done    (w_wb_done),
        .o_berr    (w_wb_berr),
        .m_bus     (m_bus)
    );

endmodule

// File: tb/tb_axi_ame_ctrl.sv
// Directed bench for axi_ame_ctrl: register map, solver handshake, write-back bursts.
module tb_axi_ame_ctrl;
    import ame_pkg::*;

    localparam int DB = 64, AB = 32, R = 6, C = 7, N = 6;

    logic            clk = 1'b0, rst_n = 1'b0;
    logic            comp_init, param6, comp_done, irq;
    logic [R*C*DB-1:0] comp_data_o;
    logic [N*DB-1:0]   comp_data_i;
    int              n_checks = 0, n_fail = 0;
    logic [63:0]     rd;

    always #5 clk = ~clk;

    axi_ame_ctrl_if #(.DATA_BITS(DB), .ADDR_BITS(AB)) bus ();

    axi_ame_ctrl #(.DATA_BITS(DB), .ROWS(R), .COLS(C), .N_RES(N), .ADDR_BITS(AB)) dut (
        .s_axi_aclk      (clk),
        .s_axi_aresetn   (rst_n),
        .s_bus           (bus),
        .m_bus           (bus),
        .comp_init_o     (comp_init),
        .affine_param6_o (param6),
        .comp_data_o     (comp_data_o),
        .comp_done_i     (comp_done),
        .comp_data_i     (comp_data_i),
        .irq_o           (irq)
    );

    task automatic axi_write(input logic [31:0] addr, input logic [63:0] data);
        int t = 0;
        @(negedge clk);
        bus.s_axi_awaddr = addr; bus.s_axi_wdata = data;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
        #1;
        while (!bus.s_axi_awready && t < 20) begin @(negedge clk); #1; t++; end
        n_checks++;
        if (bus.s_axi_awready !== 1'b1) begin
            n_fail++; $display("FAIL wr_accept addr=%h awready=%b required 1", addr, bus.s_axi_awready);
        end
        @(negedge clk);
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [63:0] data);
        int t = 0;
        @(negedge clk);
        bus.s_axi_araddr = addr; bus.s_axi_arvalid = 1'b1;
        #1;
        while (!bus.s_axi_arready && t < 20) begin @(negedge clk); #1; t++; end
        @(negedge clk);
        bus.s_axi_arvalid = 1'b0;
        data = bus.s_axi_rdata;
        n_checks++;
        if (bus.s_axi_rvalid !== 1'b1) begin
            n_fail++; $display("FAIL rd_valid addr=%h rvalid=%b required 1", addr, bus.s_axi_rvalid);
        end
    endtask

    task automatic pulse_done(input logic [63:0] base);
        @(negedge clk);
        for (int i = 0; i < N; i++) comp_data_i[i*DB +: DB] = base + 64'(i);
        comp_done = 1'b1;
        @(negedge clk);
        comp_done = 1'b0;
    endtask

    // Memory side of one write-back burst with optional AW stall and W toggling
    task automatic run_wb(input logic [63:0] base, input int aw_stall, input bit w_toggle,
                          input logic [1:0] resp);
        int beats = 0, aw_cnt = 0;
        bit aw_done = 1'b0, b_done = 1'b0, stalled = 1'b0;
        logic [63:0] held = '0;
        for (int cyc = 0; cyc < 200 && !b_done; cyc++) begin
            @(negedge clk);
            bus.m_axi_awready = !aw_done && (aw_cnt >= aw_stall);
            bus.m_axi_wready  = w_toggle ? cyc[0] : 1'b1;
            bus.m_axi_bvalid  = (beats == N);
            bus.m_axi_bresp   = resp;
            #1;
            if (bus.m_axi_awvalid) begin
                n_checks++;
                if (bus.m_axi_awaddr !== 32'h1000) begin
                    n_fail++; $display("FAIL wb_awaddr got=%h required 1000", bus.m_axi_awaddr);
                end
                if (bus.m_axi_awready) begin
                    n_checks++;
                    if (bus.m_axi_awlen !== 8'd5) begin
                        n_fail++; $display("FAIL wb_awlen got=%0d required 5", bus.m_axi_awlen);
                    end
                    aw_done = 1'b1;
                end else aw_cnt++;
            end
            if (bus.m_axi_wvalid) begin
                if (stalled) begin
                    n_checks++;
                    if (bus.m_axi_wdata !== held) begin
                        n_fail++; $display("FAIL wb_wdata_stable got=%h required %h", bus.m_axi_wdata, held);
                    end
                end
                if (bus.m_axi_wready) begin
                    n_checks++;
                    if (bus.m_axi_wdata !== base + 64'(beats) || bus.m_axi_wlast !== (beats == N-1)) begin
                        n_fail++;
                        $display("FAIL wb_beat%0d data=%h last=%b required data=%h last=%b", beats,
                                 bus.m_axi_wdata, bus.m_axi_wlast, base + 64'(beats), (beats == N-1));
                    end
                    beats++; stalled = 1'b0;
                end else begin
                    stalled = 1'b1; held = bus.m_axi_wdata;
                end
            end
            if (bus.m_axi_bvalid && bus.m_axi_bready) b_done = 1'b1;
        end
        @(negedge clk);
        bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0; bus.m_axi_bvalid = 1'b0;
        n_checks++;
        if (!b_done || beats != N) begin
            n_fail++; $display("FAIL wb_complete b_done=%b beats=%0d required 1/%0d", b_done, beats, N);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.s_axi_bvalid !== 1'b0 || bus.s_axi_rvalid !== 1'b0 || bus.m_axi_awvalid !== 1'b0 ||
            bus.m_axi_wvalid !== 1'b0 || comp_init !== 1'b0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs bv=%b rv=%b awv=%b wv=%b init=%b irq=%b required all 0",
                               bus.s_axi_bvalid, bus.s_axi_rvalid, bus.m_axi_awvalid,
                               bus.m_axi_wvalid, comp_init, irq);
        end
        n_checks++;
        if (bus.m_axi_awsize !== 3'd3 || bus.m_axi_awburst !== 2'd1 || bus.m_axi_awcache !== 4'd2 ||
            bus.m_axi_wstrb !== 8'hFF || bus.m_axi_awlen !== 8'd5) begin
            n_fail++; $display("FAIL const_fields size=%0d burst=%0d cache=%0d strb=%h len=%0d required 3/1/2/ff/5",
                               bus.m_axi_awsize, bus.m_axi_awburst, bus.m_axi_awcache,
                               bus.m_axi_wstrb, bus.m_axi_awlen);
        end
        foreach (dut.r_ctrl[i]) ;
        for (int a = 0; a < 3; a++) begin
            axi_read(32'(a * 8), rd);
            n_checks++;
            if (rd !== 64'd0) begin n_fail++; $display("FAIL reset_reg%0d got=%h required 0", a, rd); end
        end
    endtask

    task automatic test_start();
        axi_write(32'h000, 64'h1000);
        axi_write(32'h200, 64'h1234);
        axi_write(32'h348, 64'hBEEF);
        axi_write(32'h008, 64'hA);
        axi_read(32'h008, rd);
        n_checks++;
        if (rd !== 64'hA) begin n_fail++; $display("FAIL ctrl_rd got=%h required a", rd); end
        axi_write(32'h008, 64'hB);
        n_checks++;
        if (comp_init !== 1'b1 || param6 !== 1'b1) begin
            n_fail++; $display("FAIL start_pulse init=%b p6=%b required 1/1", comp_init, param6);
        end
        @(negedge clk);
        n_checks++;
        if (comp_init !== 1'b0) begin n_fail++; $display("FAIL start_one_cycle init=%b required 0", comp_init); end
        axi_read(32'h010, rd);
        n_checks++;
        if (rd !== 64'h1) begin n_fail++; $display("FAIL status_busy got=%h required 1", rd); end
        axi_read(32'h008, rd);
        n_checks++;
        if (rd !== 64'hA) begin n_fail++; $display("FAIL ctrl_selfclr got=%h required a", rd); end
        n_checks++;
        if (comp_data_o[63:0] !== 64'h1234 || comp_data_o[41*64 +: 64] !== 64'hBEEF) begin
            n_fail++; $display("FAIL comp_data m0=%h m41=%h required 1234/beef",
                               comp_data_o[63:0], comp_data_o[41*64 +: 64]);
        end
    endtask

    task automatic test_writeback();
        pulse_done(64'd1);
        run_wb(64'd1, 0, 1'b0, 2'b00);
        axi_read(32'h010, rd);
        n_checks++;
        if (rd !== 64'h2 || irq !== 1'b0) begin
            n_fail++; $display("FAIL wb_status got=%h irq=%b required 2/0", rd, irq);
        end
        for (int i = 0; i < N; i++) begin
            axi_read(32'h040 + 32'(i*8), rd);
            n_checks++;
            if (rd !== 64'(i + 1)) begin n_fail++; $display("FAIL result%0d got=%h required %0d", i, rd, i+1); end
        end
    endtask

    task automatic test_stall();
        axi_write(32'h008, 64'hF);
        pulse_done(64'h100);
        run_wb(64'h100, 10, 1'b1, 2'b00);
        axi_read(32'h010, rd);
        n_checks++;
        if (rd !== 64'h2 || irq !== 1'b1) begin
            n_fail++; $display("FAIL stall_status got=%h irq=%b required 2/1", rd, irq);
        end
    endtask

    task automatic test_berr();
        axi_write(32'h008, 64'hF);
        axi_read(32'h010, rd);
        n_checks++;
        if (rd !== 64'h1 || irq !== 1'b0) begin
            n_fail++; $display("FAIL start_clears_done got=%h irq=%b required 1/0", rd, irq);
        end
        pulse_done(64'h200);
        run_wb(64'h200, 0, 1'b0, 2'b10);
        axi_read(32'h010, rd);
        n_checks++;
        if (rd !== 64'h6 || irq !== 1'b1) begin
            n_fail++; $display("FAIL berr_status got=%h irq=%b required 6/1", rd, irq);
        end
        axi_write(32'h010, 64'h6);
        axi_read(32'h010, rd);
        n_checks++;
        if (rd !== 64'h0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL w1c_status got=%h irq=%b required 0/0", rd, irq);
        end
    endtask

    task automatic test_busy_ignore();
        axi_write(32'h008, 64'h1);
        axi_write(32'h200, 64'hAA);
        axi_write(32'h008, 64'hF);
        n_checks++;
        if (comp_init !== 1'b0) begin n_fail++; $display("FAIL busy_start init=%b required 0", comp_init); end
        axi_read(32'h008, rd);
        n_checks++;
        if (rd !== 64'h0) begin n_fail++; $display("FAIL busy_ctrl got=%h required 0", rd); end
        axi_read(32'h200, rd);
        n_checks++;
        if (rd !== 64'h1234) begin n_fail++; $display("FAIL busy_matrix got=%h required 1234", rd); end
        pulse_done(64'h40);
        axi_read(32'h010, rd);
        n_checks++;
        if (rd !== 64'h2) begin n_fail++; $display("FAIL nowb_status got=%h required 2", rd); end
        axi_write(32'h040, 64'h99);
        axi_read(32'h068, rd);
        n_checks++;
        if (rd !== 64'h45) begin n_fail++; $display("FAIL result5 got=%h required 45", rd); end
        axi_read(32'h040, rd);
        n_checks++;
        if (rd !== 64'h40) begin n_fail++; $display("FAIL result_ro got=%h required 40", rd); end
        axi_write(32'h350, 64'hDEAD);
        axi_read(32'h350, rd);
        n_checks++;
        if (rd !== 64'h0) begin n_fail++; $display("FAIL matrix42 got=%h required 0", rd); end
        axi_read(32'h348, rd);
        n_checks++;
        if (rd !== 64'hBEEF) begin n_fail++; $display("FAIL matrix41 got=%h required beef", rd); end
    endtask

    task automatic test_reset_midburst();
        int beats = 0;
        bit hit = 1'b0;
        axi_write(32'h008, 64'h9);
        pulse_done(64'h300);
        for (int cyc = 0; cyc < 50 && !hit; cyc++) begin
            @(negedge clk);
            bus.m_axi_awready = 1'b1; bus.m_axi_wready = 1'b1;
            #1;
            if (bus.m_axi_wvalid && beats == 2) begin
                n_checks++;
                if (bus.m_axi_wdata !== 64'h302) begin
                    n_fail++; $display("FAIL beat3_data got=%h required 302", bus.m_axi_wdata);
                end
                rst_n = 1'b0;
                #1;
                n_checks++;
                if (bus.m_axi_wvalid !== 1'b0 || bus.m_axi_awvalid !== 1'b0 || bus.m_axi_bready !== 1'b0 ||
                    comp_init !== 1'b0 || irq !== 1'b0 || bus.s_axi_bvalid !== 1'b0) begin
                    n_fail++; $display("FAIL rst_outputs wv=%b awv=%b br=%b init=%b irq=%b bv=%b required all 0",
                                       bus.m_axi_wvalid, bus.m_axi_awvalid, bus.m_axi_bready,
                                       comp_init, irq, bus.s_axi_bvalid);
                end
                hit = 1'b1;
            end else if (bus.m_axi_wvalid) beats++;
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL rst_beat3_seen got=0 required 1"); end
        @(negedge clk);
        bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
        rst_n = 1'b1;
        n_checks++;
        if (comp_data_o !== '0) begin n_fail++; $display("FAIL rst_matrix_out got=nonzero required 0"); end
        for (int a = 0; a < 4; a++) begin
            logic [31:0] addr;
            addr = (a == 3) ? 32'h040 : 32'(a * 8);
            axi_read(addr, rd);
            n_checks++;
            if (rd !== 64'd0) begin n_fail++; $display("FAIL rst_reg addr=%h got=%h required 0", addr, rd); end
        end
        axi_read(32'h348, rd);
        n_checks++;
        if (rd !== 64'd0) begin n_fail++; $display("FAIL rst_matrix41 got=%h required 0", rd); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0; bus.s_axi_wdata = '0; bus.s_axi_wvalid = 1'b0;
        bus.s_axi_bready = 1'b1; bus.s_axi_araddr = '0; bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b1;
        bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0; bus.m_axi_bresp = 2'b00; bus.m_axi_bvalid = 1'b0;
        comp_done = 1'b0; comp_data_i = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_start();
        test_writeback();
        test_stall();
        test_berr();
        test_busy_ignore();
        test_reset_midburst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_ame_ctrl.md
AXI_AME_CTRL -- requirements
Module: axi_ame_ctrl

Interface
REQ-001 Parameter DATA_BITS, default 64: data width of the register bus, the memory bus and the solver words.
REQ-002 Parameter ROWS, default 6; parameter COLS, default 7: shape of the input matrix held in the register file.
REQ-003 Parameter N_RES, default 6 (range 1..16): number of solver results held and written back.
REQ-004 Parameter ADDR_BITS, default 32: width of all AXI addresses.
REQ-005 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-006 s_axi_aclk  in  1  sole clock for every register in the block.
REQ-007 s_axi_aresetn  in  1  asynchronous active-low reset.
REQ-008 s_axi_awaddr/awvalid/awready  in/in/out  ADDR_BITS/1/1  slave write address.
REQ-009 s_axi_wdata/wvalid/wready  in/in/out  DATA_BITS/1/1  slave write data.
REQ-010 s_axi_bvalid/bready  out/in  1/1  slave write response.
REQ-011 s_axi_araddr/arvalid/arready  in/in/out  ADDR_BITS/1/1  slave read address.
REQ-012 s_axi_rdata/rvalid/rready  out/out/in  DATA_BITS/1/1  slave read data.
REQ-013 m_axi_awaddr/awlen/awvalid/awready  out/out/out/in  ADDR_BITS/8/1/1  master write address.
REQ-014 m_axi_awsize/awburst/awlock/awcache/awprot/awqos  out  3/2/1/4/3/4  constants log2(DATA_BITS/8), INCR, 0, 2, 0, 0.
REQ-015 m_axi_wdata/wstrb/wlast/wvalid/wready  out/out/out/out/in  DATA_BITS/DATA_BITS/8/1/1/1  master write data; wstrb all ones.
REQ-016 m_axi_bresp/bvalid/bready  in/in/out  2/1/1  master write response.
REQ-017 comp_init_o/affine_param6_o/comp_data_o  out  1/1/ROWS*COLS*DATA_BITS  solver start pulse, mode bit, matrix.
REQ-018 comp_done_i/comp_data_i  in  1/N_RES*DATA_BITS  solver completion pulse and results.
REQ-019 irq_o  out  1  level interrupt = DONE & IRQ_EN.

Function
REQ-020 Register map (byte offset, 8-byte stride, decoded on addr[9:0]): 0x000 WB_BASE RW; 0x008 CTRL (bit0 START W1 self-clearing, bit1 PARAM6, bit2 IRQ_EN, bit3 WB_EN); 0x010 STATUS (bit0 BUSY RO, bit1 DONE W1C, bit2 BERR W1C); 0x040+8i RESULT[i] RO, i<N_RES; 0x200+8k MATRIX[k] RW, k=r*COLS+c<ROWS*COLS.
REQ-021 Reads of unmapped offsets SHALL return 0; writes to unmapped or RO offsets SHALL be accepted and ignored.
REQ-022 A slave write SHALL be accepted (awready=wready=1, same cycle) only when awvalid & wvalid & (!bvalid | bready); bvalid rises the next cycle and holds until bready.
REQ-023 A slave read SHALL be accepted when arvalid & (!rvalid | rready); rdata/rvalid are registered one cycle later and held stable until rready.
REQ-024 FSM states: IDLE, COMP, WB_AW, WB_W, WB_B.
REQ-025 IDLE->COMP on a START write: comp_init_o pulses for exactly one cycle and DONE/BERR clear; START while BUSY is ignored.
REQ-026 COMP on comp_done_i: capture comp_data_i into RESULT[]; go to WB_AW if WB_EN, else IDLE with DONE set.
REQ-027 WB_AW: m_axi_awvalid=1, awaddr=WB_BASE, awlen=N_RES-1, held stable until awready; then WB_W.
REQ-028 WB_W: N_RES beats of RESULT[0..N_RES-1] in order; beat advances only on wvalid & wready; wlast only on beat N_RES-1.
REQ-029 WB_B: m_axi_bready=1; on bvalid set DONE, set BERR if bresp!=0, return to IDLE.
REQ-030 BUSY SHALL be 1 in every state but IDLE; MATRIX and CTRL[3:1] writes while BUSY SHALL be ignored.
REQ-031 DONE set and a W1C clear in the same cycle: set wins.

Reset
REQ-032 Reset SHALL force IDLE, all registers/RESULT/MATRIX to 0, every valid/ready/pulse output and irq_o to 0, immediately and regardless of state, including mid-burst.

Structure
REQ-033 Package ame_pkg SHALL hold the FSM state enum, register offsets and CTRL/STATUS bit positions.
REQ-034 The master write path (WB_AW/WB_W/WB_B) SHALL be sub-module axi_ame_wb; the solver stays outside this block.

Verification
REQ-035 Write 0x1000 to WB_BASE, 0xA to CTRL (WB_EN, PARAM6), then 0xB -> one-cycle comp_init_o, affine_param6_o=1, BUSY=1.
REQ-036 comp_done_i with results 1..6 -> awaddr=0x1000, awlen=5, six beats 1..6, wlast on 6th only, DONE=1, irq_o=1 if IRQ_EN.
REQ-037 awready low 10 cycles and wready toggling -> awaddr/wdata stable while stalled, no beat lost or repeated.
REQ-038 bresp=2 -> BERR=1; write 0x6 to STATUS -> DONE=BERR=0, irq_o=0.
REQ-039 START and MATRIX[0] writes while BUSY -> ignored; MATRIX[42] write -> read back 0.
REQ-040 Reset asserted on 3rd W beat -> m_axi_wvalid=0 same cycle, BUSY=0, all registers read 0.
